fp_result_pack: RTL

FP_RESULT_PACK -- requirements
Module: fp_result_pack

---
 rtl/fp_result_pack_if.sv | 24 ++
 rtl/fp_result_pack.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fp_result_pack_if.sv
// Handshake bundle between the multiplier core and the result packer.
// master = producer/consumer environment, slave = the packer itself.
interface fp_result_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [9:0]  exp_in;
    logic [47:0] mant_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    modport master (
        output in_valid, sign_in, exp_in, mant_in, out_ready,
        input  in_ready, out_valid, result, overflow, underflow
    );

    modport slave (
        input  in_valid, sign_in, exp_in, mant_in, out_ready,
        output in_ready, out_valid, result, overflow, underflow
    );
endinterface

// File: rtl/fp_result_pack.sv
// Normalizes, rounds (nearest-even) and packs a raw 24x24 significand product
// into an IEEE-754 single with overflow saturation and flush-to-zero.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// NORM  | select significand window, guard and sticky
// ROUND | round, renormalize on carry, pack result and flags
// DONE  | out_valid=1, hold until out_ready
module fp_result_pack (
    input  logic              clk,
    input  logic              rst,
    fp_result_pack_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t             state, state_nxt;
    logic               sign_r;
    logic [9:0]         exp_r;
    logic [47:0]        mant_r;
    logic [23:0]        sig_r;
    logic               guard_r;
    logic               sticky_r;
    logic signed [10:0] e_r;
    logic [31:0]        result_r;
    logic               of_r;
    logic               uf_r;

    logic               inc;
    logic [24:0]        sum;
    logic [22:0]        frac_rnd;
    logic signed [10:0] e_rnd;
    logic [31:0]        pack_res;
    logic               pack_of;
    logic               pack_uf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.overflow  = (state == DONE) & of_r;
        bus.underflow = (state == DONE) & uf_r;
        bus.result    = result_r;
    end

    // A nonzero product always leaves the hidden bit at sum[23] (or sum[24] after
    // a rounding carry), so an all-zero mantissa is detected without a flag.
    always_comb begin
        inc = guard_r & (sticky_r | sig_r[0]);
        sum = {1'b0, sig_r} + {24'd0, inc};
        if (sum[24]) begin
            frac_rnd = 23'd0;
            e_rnd    = e_r + 11'sd1;
        end else begin
            frac_rnd = sum[22:0];
            e_rnd    = e_r;
        end
        pack_of  = 1'b0;
        pack_uf  = 1'b0;
        if (!(sum[24] | sum[23])) begin
            pack_res = {sign_r, 31'd0};
        end else if (e_rnd >= 11'sd255) begin
            pack_res = {sign_r, 8'hFF, 23'd0};
            pack_of  = 1'b1;
        end else if (e_rnd <= 11'sd0) begin
            pack_res = {sign_r, 31'd0};
            pack_uf  = 1'b1;
        end else begin
            pack_res = {sign_r, e_rnd[7:0], frac_rnd};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r   <= 1'b0;
            exp_r    <= 10'd0;
            mant_r   <= 48'd0;
            sig_r    <= 24'd0;
            guard_r  <= 1'b0;
            sticky_r <= 1'b0;
            e_r      <= 11'sd0;
            result_r <= 32'd0;
            of_r     <= 1'b0;
            uf_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_r <= bus.sign_in;
                        exp_r  <= bus.exp_in;
                        mant_r <= bus.mant_in;
                    end
                end
                NORM: begin
                    if (mant_r[47]) begin
                        sig_r    <= mant_r[47:24];
                        guard_r  <= mant_r[23];
                        sticky_r <= |mant_r[22:0];
                        e_r      <= $signed({exp_r[9], exp_r}) + 11'sd1;
                    end else begin
                        sig_r    <= mant_r[46:23];
                        guard_r  <= mant_r[22];
                        sticky_r <= |mant_r[21:0];
                        e_r      <= $signed({exp_r[9], exp_r});
                    end
                end
                ROUND: begin
                    result_r <= pack_res;
                    of_r     <= pack_of;
                    uf_r     <= pack_uf;
                end
                default: ;
            endcase
        end
    end
endmodule
